uart_pkt_rx: RTL and testbench
==============================

Name: uart_pkt_rx

Overview:
Parametrised UART packet receiver; generalised successor of the fixed 5-byte, 8-bit, one-sample-per-bit receiver. Deserialises PKT_BYTES frames of DATA_BITS each from uart_in into one flat packet word. Supports configurable oversampling, framing-error recovery and inter-byte timeout. Hands each packet to the router ingress with a valid/ready handshake.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; range 5..9
PKT_BYTES, 5, frames per packet; range 1..16
OVERSAMPLE, 1, clk_19k2 cycles per bit; 1 or power of 2 from 4 to 16
IDLE_TIMEOUT, 32, bit-times of idle line that abort a partial packet; minimum 2

Ports:
clk_19k2  in  1  sample clock running at OVERSAMPLE x baud; 19.2 kHz at the default setting
rst_n  in  1  asynchronous, active-low reset
uart_in  in  1  serial line; idle high
pkt_data  out  PKT_BYTES*DATA_BITS  assembled packet; frame 0 in the LSBs
pkt_valid  out  1  packet available
pkt_ready  in  1  consumer accepts the packet when pkt_valid && pkt_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
overflow  out  1  one-cycle pulse: completed packet dropped because the previous one is still held
timeout  out  1  one-cycle pulse: partial packet discarded after idle
busy  out  1  high while a frame or partial packet is in progress

Behaviour:
- Reset: pkt_data=0, pkt_valid=0, all pulses=0, busy=0. Synchroniser flops reset to 1. FSM goes to IDLE; byte index and timeout counters go to 0.
- uart_in passes through a 2-flop synchroniser. All sampling uses the synchronised value rx_s.
- Byte FSM:
  - IDLE: on rx_s==0, go to START.
  - START, OVERSAMPLE=1: the detecting sample is the start bit. Go to DATA; the next cycle samples bit 0.
  - START, OVERSAMPLE>1: wait OVERSAMPLE/2-1 cycles, then re-check rx_s. If high, it is a false start: go to IDLE with no error. If low, go to DATA.
  - DATA: sample one bit every OVERSAMPLE cycles, LSB first, DATA_BITS samples total, then go to STOP (or PARITY when enabled).
  - STOP: sample once. If 1, the byte is good: store it at slot idx, idx++, go to IDLE. If 0, pulse frame_err, discard the partial packet (idx=0), then stay in IDLE-wait until rx_s==1 before arming for a new start.
- Packet completion: the byte at idx==PKT_BYTES-1 is stored and completes the packet.
  - If pkt_valid==0, or pkt_valid&&pkt_ready in the same cycle: load pkt_data and set pkt_valid the next cycle; idx returns to 0.
  - Otherwise: pulse overflow, drop the new packet, keep the held packet unchanged; idx returns to 0.
- Latency: pkt_valid rises 1 cycle after the last stop-bit sample (3 cycles after the matching uart_in edge, counting the synchroniser).
- Handshake: pkt_data is stable while pkt_valid=1. pkt_valid clears the cycle after acceptance.
- Timeout: the counter runs in IDLE only while 0<idx<PKT_BYTES and counts bit-times. It resets on any start detection. At IDLE_TIMEOUT: pulse timeout, set idx=0. A held pkt_valid packet is unaffected.
- busy = (FSM!=IDLE) || (idx!=0).
- Simultaneous events: a frame_err on the final byte yields no packet and no overflow. Timeout and a start detection in the same cycle: the start wins and the counter resets.
- Reset mid-frame: aborts immediately; no pulses are emitted.

Optional Feature:
UART_PKT_PARITY_EN
- Defined: a PARITY state follows DATA and samples one even-parity bit. A mismatch pulses frame_err and discards the packet, exactly like a bad stop bit.
- Undefined: there is no PARITY state; STOP directly follows DATA.

Decomposition:
- Package uart_pkg: the byte FSM state enum (IDLE, START, DATA, PARITY, STOP), the PARITY_EVEN constant, and the width helper for the idx/timeout counters (clog2).
- Sub-module uart_byte_rx: synchroniser, oversample counter and byte FSM. Outputs byte_data/byte_strobe/byte_ferr.
- Top-level uart_pkt_rx: packet slotting, idx, timeout, handshake and overflow.

Test Plan:
- Defaults; send bytes 0xC7, 0xF7, 0x0E, 0x81, 0x45 with 4 idle bits between frames; pkt_ready=1 -> pkt_valid pulses once, pkt_data=0x45810EF7C7, no error pulses.
- Hold pkt_ready=0; send two full packets -> first packet held unchanged, overflow pulses once at the 2nd packet's last stop bit; raise pkt_ready -> first packet accepted, pkt_valid drops.
- Stop bit of byte 2 forced 0 -> frame_err pulses once, idx=0, busy drops once the line idles; the next clean 5 frames produce the correct packet.
- Send 3 frames, then idle for 32 bit-times -> timeout pulses once, busy=0; a following full packet is received intact.
- OVERSAMPLE=16: a 4-cycle low glitch is rejected as a false start (no pulses); a full packet with ±3-cycle bit jitter is received correctly.
- UART_PKT_PARITY_EN defined: 0xC7 with parity 1 is accepted; the same byte with parity 0 causes a frame_err pulse and no pkt_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART packet receiver: byte FSM states, parity sense, counter sizing.
// The PARITY state is only reachable when UART_PKT_PARITY_EN is defined.
package uart_pkg;

  // BREAK holds off re-arming after a framing error until the line returns high.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;

  // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Single-frame UART deserialiser: 2-flop synchroniser, oversample counter and byte FSM.
// Define UART_PKT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 1
) (
  input  logic                 clk_19k2,
  input  logic                 rst_n,
  input  logic                 uart_in,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_strobe,
  output logic                 byte_ferr,
  output logic                 rx_idle,
  output logic                 start_det
);

  localparam int OS_W  = cnt_width(OVERSAMPLE - 1);
  localparam int BIT_W = cnt_width(DATA_BITS - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'((OVERSAMPLE > 1) ? OVERSAMPLE / 2 - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick;

  // NOTE: non-blocking assignments in clocked blocks keep every flop sampling the pre-edge value.
  always_ff @(posedge clk_19k2 or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_in};
  end

  assign rx_s      = sync_q[1];
  assign tick      = (os_cnt == OS_LAST);
  assign rx_idle   = (state == ST_IDLE);
  assign start_det = rx_idle && !rx_s;

  always_ff @(posedge clk_19k2 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte_data   <= '0;
      byte_strobe <= 1'b0;
      byte_ferr   <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      byte_ferr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            // Without oversampling the detecting sample already is the start bit.
            state   <= (OVERSAMPLE == 1) ? ST_DATA : ST_START;
          end
        end
        ST_START: begin
          if (os_cnt == HALF_LAST) begin
            os_cnt <= '0;
            state  <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            os_cnt  <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_PKT_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
`ifdef UART_PKT_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            os_cnt <= '0;
            if (rx_s == (^shift_q ^ PARITY_EVEN)) begin
              state <= ST_STOP;
            end else begin
              byte_ferr <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            os_cnt <= '0;
            if (rx_s) begin
              byte_data   <= shift_q;
              byte_strobe <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              byte_ferr <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_pkt_rx.sv
// UART packet receiver: slots frames into a packet, aborts idle partial packets, valid/ready hand-off.
// Define UART_PKT_PARITY_EN to require an even-parity bit in every frame.
module uart_pkt_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PKT_BYTES    = 5,
  parameter int OVERSAMPLE   = 1,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                           clk_19k2,
  input  logic                           rst_n,
  input  logic                           uart_in,
  output logic [PKT_BYTES*DATA_BITS-1:0] pkt_data,
  output logic                           pkt_valid,
  input  logic                           pkt_ready,
  output logic                           frame_err,
  output logic                           overflow,
  output logic                           timeout,
  output logic                           busy
);

  localparam int PKT_W     = PKT_BYTES * DATA_BITS;
  localparam int IDX_W     = cnt_width(PKT_BYTES - 1);
  localparam int TO_CYCLES = IDLE_TIMEOUT * OVERSAMPLE;
  localparam int TO_W      = cnt_width(TO_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYCLES - 1);

  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_strobe;
  logic                 byte_ferr;
  logic                 rx_idle;
  logic                 start_det;
  logic [IDX_W-1:0]     idx;
  logic [TO_W-1:0]      to_cnt;
  logic [PKT_W-1:0]     asm_q;
  logic [PKT_W-1:0]     asm_next;
  logic                 to_run;

  uart_byte_rx #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_byte_rx (
    .clk_19k2    (clk_19k2),
    .rst_n       (rst_n),
    .uart_in     (uart_in),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .byte_ferr   (byte_ferr),
    .rx_idle     (rx_idle),
    .start_det   (start_det)
  );

  // NOTE: assigning a default first means every path writes asm_next, so no latch is inferred.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (idx == IDX_W'(i)) asm_next[i*DATA_BITS +: DATA_BITS] = byte_data;
    end
  end

  // NOTE: asm_q has no reset; every slot is rewritten before a packet is released from it.
  always_ff @(posedge clk_19k2) begin
    if (byte_strobe) asm_q <= asm_next;
  end

  // A start detection restarts the idle count, so it always beats a coincident timeout.
  assign to_run = rx_idle && !start_det && (idx != '0);

  always_ff @(posedge clk_19k2 or negedge rst_n) begin
    if (!rst_n) begin
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      idx       <= '0;
      to_cnt    <= '0;
    end else begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
      if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;

      if (byte_ferr) begin
        idx    <= '0;
        to_cnt <= '0;
      end else if (byte_strobe) begin
        to_cnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
          if (!pkt_valid || pkt_ready) begin
            pkt_data  <= asm_next;
            pkt_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (to_run) begin
        if (to_cnt == TO_LAST) begin
          timeout <= 1'b1;
          idx     <= '0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign frame_err = byte_ferr;
  assign busy      = !rx_idle || (idx != '0);

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Scoreboard bench for uart_pkt_rx: one receiver at OVERSAMPLE=1, one at OVERSAMPLE=16.
// Parity scenarios run only when UART_PKT_PARITY_EN is defined.
module tb_uart_pkt_rx;

  typedef enum logic [2:0] {EV_NONE, EV_PKT, EV_FERR, EV_OVF, EV_TO} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [39:0] data;
  } ev_t;
  typedef enum int {ERR_NONE, ERR_STOP, ERR_PAR} frame_err_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line0, line1;
  logic        ready0, ready1;
  logic [39:0] pkt_data0, pkt_data1;
  logic        pkt_valid0, pkt_valid1;
  logic        frame_err0, frame_err1;
  logic        overflow0, overflow1;
  logic        timeout0, timeout1;
  logic        busy0, busy1;

  int total = 0;
  int bad   = 0;

  ev_t exp_q0[$];
  ev_t exp_q1[$];

  int jit_tab[8] = '{3, -3, 2, -2, 3, -1, 1, -3};

  always #5 clk = ~clk;

  uart_pkt_rx dut0 (
    .clk_19k2  (clk),
    .rst_n     (rst_n),
    .uart_in   (line0),
    .pkt_data  (pkt_data0),
    .pkt_valid (pkt_valid0),
    .pkt_ready (ready0),
    .frame_err (frame_err0),
    .overflow  (overflow0),
    .timeout   (timeout0),
    .busy      (busy0)
  );

  uart_pkt_rx #(.OVERSAMPLE(16)) dut1 (
    .clk_19k2  (clk),
    .rst_n     (rst_n),
    .uart_in   (line1),
    .pkt_data  (pkt_data1),
    .pkt_valid (pkt_valid1),
    .pkt_ready (ready1),
    .frame_err (frame_err1),
    .overflow  (overflow1),
    .timeout   (timeout1),
    .busy      (busy1)
  );

  logic        pv[2], fe[2], ov[2], to[2], rdy[2];
  logic [39:0] pd[2];
  assign pv[0] = pkt_valid0;  assign pv[1] = pkt_valid1;
  assign fe[0] = frame_err0;  assign fe[1] = frame_err1;
  assign ov[0] = overflow0;   assign ov[1] = overflow1;
  assign to[0] = timeout0;    assign to[1] = timeout1;
  assign rdy[0] = ready0;     assign rdy[1] = ready1;
  assign pd[0] = pkt_data0;   assign pd[1] = pkt_data1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int d, input ev_kind_e kind, input logic [39:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic expect_ev(input int d, input ev_kind_e kind, input logic [39:0] data);
    ev_t e;
    e.kind = EV_NONE;
    e.data = '0;
    if (d == 0) begin
      if (exp_q0.size() > 0) e = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() > 0) e = exp_q1.pop_front();
    end
    check($sformatf("dut%0d_event_kind", d), 64'(kind), 64'(e.kind));
    if (kind == EV_PKT && e.kind == EV_PKT)
      check($sformatf("dut%0d_pkt_data", d), 64'(data), 64'(e.data));
  endtask

  // Monitor: every DUT output event must match the head of that DUT's expectation queue.
  bit          prev_pv[2]  = '{1'b0, 1'b0};
  bit          prev_rdy[2] = '{1'b0, 1'b0};
  logic [39:0] prev_pd[2];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (fe[d] === 1'b1) expect_ev(d, EV_FERR, '0);
        if (ov[d] === 1'b1) expect_ev(d, EV_OVF, '0);
        if (to[d] === 1'b1) expect_ev(d, EV_TO, '0);
        if (pv[d] === 1'b1 && (!prev_pv[d] || prev_rdy[d])) expect_ev(d, EV_PKT, pd[d]);
        if (pv[d] === 1'b1 && prev_pv[d] && !prev_rdy[d])
          check($sformatf("dut%0d_pkt_hold", d), 64'(pd[d]), 64'(prev_pd[d]));
        prev_pv[d]  = (pv[d] === 1'b1);
        prev_rdy[d] = (rdy[d] === 1'b1);
        prev_pd[d]  = pd[d];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v);
    if (d == 0) line0 = v;
    else        line1 = v;
  endtask

  task automatic idle_bits(input int d, input int nbits);
    drive(d, 1'b1);
    tick(nbits * ((d == 0) ? 1 : 16));
  endtask

  // Frame = start, 8 data bits LSB first, optional even parity, stop; edges optionally jittered.
  task automatic send_frame(input int d, input logic [7:0] b, input frame_err_e err, input bit jit);
    logic bits [0:11];
    int   n, os, jprev, jcur;
    os = (d == 0) ? 1 : 16;
    n = 0;
    bits[n] = 1'b0;
    n = n + 1;
    for (int i = 0; i < 8; i++) begin
      bits[n] = b[i];
      n = n + 1;
    end
`ifdef UART_PKT_PARITY_EN
    bits[n] = (^b) ^ (err == ERR_PAR);
    n = n + 1;
`endif
    bits[n] = (err != ERR_STOP);
    n = n + 1;
    jprev = 0;
    for (int k = 0; k < n; k++) begin
      jcur = (jit && k < n - 1) ? jit_tab[(k + 1) % 8] : 0;
      drive(d, bits[k]);
      tick(os + jcur - jprev);
      jprev = jcur;
    end
  endtask

  task automatic send_pkt(input int d, input logic [39:0] p, input bit jit);
    for (int i = 0; i < 5; i++) begin
      send_frame(d, p[i*8 +: 8], ERR_NONE, jit);
      idle_bits(d, 4);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    line0  = 1'b1;
    line1  = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    check("rst_pkt_data", 64'(pkt_data0), 64'h0);
    check("rst_pkt_valid", 64'(pkt_valid0), 64'h0);
    check("rst_busy", 64'(busy0), 64'h0);
    check("rst_pulses", 64'({frame_err0, overflow0, timeout0}), 64'h0);
    check("rst_dut1_valid_busy", 64'({pkt_valid1, busy1}), 64'h0);

    // Basic packet, with the 1-cycle-after-stop-sample latency checked directly.
    push_ev(0, EV_PKT, 40'h45810EF7C7);
    send_frame(0, 8'hC7, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'hF7, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h0E, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h81, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h45, ERR_NONE, 1'b0);
    drive(0, 1'b1);
    tick(2);
    check("latency_before", 64'(pkt_valid0), 64'h0);
    tick(1);
    check("latency_valid", 64'(pkt_valid0), 64'h1);
    check("latency_data", 64'(pkt_data0), 64'h45810EF7C7);
    tick(1);
    check("valid_drops_after_accept", 64'(pkt_valid0), 64'h0);
    idle_bits(0, 8);
    check("busy_after_pkt", 64'(busy0), 64'h0);

    // Overflow: the held packet survives a second complete packet.
    ready0 = 1'b0;
    push_ev(0, EV_PKT, 40'h5544332211);
    send_pkt(0, 40'h5544332211, 1'b0);
    send_frame(0, 8'hA1, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'hA2, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'hA3, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'hA4, ERR_NONE, 1'b0); idle_bits(0, 4);
    push_ev(0, EV_OVF, '0);
    send_frame(0, 8'hA5, ERR_NONE, 1'b0); idle_bits(0, 8);
    check("ovf_held_valid", 64'(pkt_valid0), 64'h1);
    check("ovf_held_data", 64'(pkt_data0), 64'h5544332211);
    ready0 = 1'b1;
    tick(1);
    check("ovf_accept_drop", 64'(pkt_valid0), 64'h0);
    idle_bits(0, 4);

    // Framing error on byte 2, then a clean packet.
    send_frame(0, 8'h12, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h34, ERR_NONE, 1'b0); idle_bits(0, 4);
    push_ev(0, EV_FERR, '0);
    send_frame(0, 8'h56, ERR_STOP, 1'b0);
    tick(5);
    check("ferr_busy_while_low", 64'(busy0), 64'h1);
    drive(0, 1'b1);
    tick(4);
    check("ferr_busy_after_idle", 64'(busy0), 64'h0);
    idle_bits(0, 4);
    push_ev(0, EV_PKT, 40'h13F0DEBC9A);
    send_pkt(0, 40'h13F0DEBC9A, 1'b0);

    // Inter-byte timeout after three frames, then a clean packet.
    push_ev(0, EV_TO, '0);
    send_frame(0, 8'h01, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h02, ERR_NONE, 1'b0); idle_bits(0, 4);
    send_frame(0, 8'h03, ERR_NONE, 1'b0); idle_bits(0, 4);
    check("to_busy_partial", 64'(busy0), 64'h1);
    idle_bits(0, 40);
    check("to_busy_cleared", 64'(busy0), 64'h0);
    push_ev(0, EV_PKT, 40'h6E5D4C3B2A);
    send_pkt(0, 40'h6E5D4C3B2A, 1'b0);

    // OVERSAMPLE=16: glitch rejection, then a jittered packet.
    drive(1, 1'b0);
    tick(4);
    drive(1, 1'b1);
    tick(40);
    check("os16_glitch_not_busy", 64'(busy1), 64'h0);
    push_ev(1, EV_PKT, 40'h0123456789);
    send_pkt(1, 40'h0123456789, 1'b1);
    idle_bits(1, 4);
    check("os16_busy_after_pkt", 64'(busy1), 64'h0);

`ifdef UART_PKT_PARITY_EN
    // Good parity accepted into slot 0; bad parity on the next frame discards it.
    send_frame(0, 8'hC7, ERR_NONE, 1'b0); idle_bits(0, 4);
    check("par_good_busy", 64'(busy0), 64'h1);
    push_ev(0, EV_FERR, '0);
    send_frame(0, 8'hC7, ERR_PAR, 1'b0); idle_bits(0, 6);
    check("par_bad_busy", 64'(busy0), 64'h0);
    check("par_bad_no_valid", 64'(pkt_valid0), 64'h0);
    push_ev(0, EV_PKT, 40'h45810EF7C7);
    send_pkt(0, 40'h45810EF7C7, 1'b0);
`endif

    tick(50);
    check("dut0_events_all_seen", 64'(exp_q0.size()), 64'h0);
    check("dut1_events_all_seen", 64'(exp_q1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
